// File: rtl/vram_dp_ctrl_pkg.sv
// Shared video-memory definitions: read-during-write mode codes and clear-engine states.
package vram_dp_ctrl_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vram_dp_array.sv
// Raw single-clock dual-port RAM with per-byte write enables.
module vram_dp_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 15,
  parameter int DEPTH     = 32768,
  parameter     INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic                  a_re,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_din,
  output logic [DATA_W-1:0]     a_q,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic                  b_re,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_din,
  output logic [DATA_W-1:0]     b_q
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // NOTE: the storage array has no reset; only control state is reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] a_idx, b_idx;
  assign a_idx = a_addr[IDX_W-1:0];
  assign b_idx = b_addr[IDX_W-1:0];

  // NOTE: non-blocking writes mean a read in the same edge sees the old word (read-first).
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (b_we && b_be[i]) mem[b_idx][8*i +: 8] <= b_din[8*i +: 8];
      if (a_we && a_be[i]) mem[a_idx][8*i +: 8] <= a_din[8*i +: 8];
    end
    if (a_re) a_q <= mem[a_idx];
    if (b_re) b_q <= mem[b_idx];
  end

endmodule

// File: rtl/vram_dp_ctrl.sv
// Dual-port VRAM controller: byte-enabled CPU/CRTC ports, collision policy, optional
// output register, read-valid strobes and a fill-with-constant clear engine.
module vram_dp_ctrl
  import vram_dp_ctrl_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 15,
  parameter int                DEPTH          = 32768,
  parameter int                OUT_REG        = 0,
  parameter int                RDW_MODE       = 0,
  parameter int                CLEAR_ON_RESET = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter                    INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  output logic                busy,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_din,
  output logic [DATA_W-1:0]   a_dout,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_din,
  output logic [DATA_W-1:0]   b_dout,
  output logic                b_rvalid
);

  localparam int              NB      = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic            WF      = (RDW_MODE == RDW_WRITE_FIRST);

  clr_state_e      state_q, state_d;
  logic [ADDR_W:0] cnt_q;
  logic            start_pend_q;

  logic a_inr, b_inr, a_acc, b_acc, a_wr, b_wr, a_rd, b_rd, same_addr;
  logic [NB-1:0] b_be_eff;

  assign a_inr     = ({1'b0, a_addr} < DEPTH_L);
  assign b_inr     = ({1'b0, b_addr} < DEPTH_L);
  assign a_acc     = a_en && !busy;
  assign b_acc     = b_en && !busy;
  assign a_wr      = a_acc && a_we && a_inr;
  assign b_wr      = b_acc && b_we && b_inr;
  assign a_rd      = a_acc && !a_we;
  assign b_rd      = b_acc && !b_we;
  assign same_addr = (a_addr == b_addr);

  // Port A owns every byte it enables on a same-address double write.
  assign b_be_eff = (a_wr && b_wr && same_addr) ? (b_be & ~a_be) : b_be;

  logic                arr_a_we;
  logic [NB-1:0]       arr_a_be;
  logic [ADDR_W-1:0]   arr_a_addr;
  logic [DATA_W-1:0]   arr_a_din;

  // The clear engine borrows port A of the array while busy.
  assign arr_a_we   = busy || a_wr;
  assign arr_a_be   = busy ? {NB{1'b1}} : a_be;
  assign arr_a_addr = busy ? cnt_q[ADDR_W-1:0] : a_addr;
  assign arr_a_din  = busy ? CLEAR_VAL : a_din;

  logic [1:0][DATA_W-1:0] q, rdata, bdat_q, dout;
  logic [1:0][NB-1:0]     bbe_q;
  logic [1:0]             rd_q, oor_q, byp_q, rvalid;

  vram_dp_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .a_we   (arr_a_we),
    .a_be   (arr_a_be),
    .a_re   (a_rd),
    .a_addr (arr_a_addr),
    .a_din  (arr_a_din),
    .a_q    (q[0]),
    .b_we   (b_wr),
    .b_be   (b_be_eff),
    .b_re   (b_rd),
    .b_addr (b_addr),
    .b_din  (b_din),
    .b_q    (q[1])
  );

  // Read stage: remember which reads are live, out of range, or need the other port's write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      byp_q <= '0;
    end else begin
      rd_q  <= {b_rd, a_rd};
      byp_q <= {WF && b_rd && a_wr && same_addr, WF && a_rd && b_wr && same_addr};
    end
  end

  always_ff @(posedge clk) begin
    oor_q     <= {!b_inr, !a_inr};
    bdat_q[0] <= b_din;
    bbe_q[0]  <= b_be_eff;
    bdat_q[1] <= a_din;
    bbe_q[1]  <= a_be;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata = q;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) begin
        if (byp_q[p] && bbe_q[p][i]) rdata[p][8*i +: 8] = bdat_q[p][8*i +: 8];
      end
      if (oor_q[p]) rdata[p] = CLEAR_VAL;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_out
    logic [DATA_W-1:0] dout_q;
    if (OUT_REG != 0) begin : g_reg
      logic rv_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= rd_q[p];
          if (rd_q[p]) dout_q <= rdata[p];
        end
      end
      assign dout[p]   = dout_q;
      assign rvalid[p] = rv_q;
    end else begin : g_hold
      // Holding register keeps the last read on the bus between reads.
      always_ff @(posedge clk) begin
        if (reset)         dout_q <= '0;
        else if (rd_q[p])  dout_q <= rdata[p];
      end
      assign dout[p]   = rd_q[p] ? rdata[p] : dout_q;
      assign rvalid[p] = rd_q[p];
    end
  end

  assign a_dout   = dout[0];
  assign b_dout   = dout[1];
  assign a_rvalid = rvalid[0];
  assign b_rvalid = rvalid[1];

  // Clear engine: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLR_IDLE;
      cnt_q        <= '0;
      start_pend_q <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q      <= state_d;
      start_pend_q <= 1'b0;
      if (state_q == CLR_RUN) cnt_q <= (cnt_q == LAST_L) ? '0 : cnt_q + 1'b1;
    end
  end

  // Clear engine: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLR_IDLE: if (clear_req || start_pend_q) state_d = CLR_RUN;
      CLR_RUN:  if (cnt_q == LAST_L)           state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  // Clear engine: outputs.
  always_comb begin
    busy = (state_q == CLR_RUN);
  end

endmodule
